vc_arbiter: RTL and testbench

Round-robin dequeue and routing stage placed directly downstream of the two virtual-channel FIFOs of the transaction layer. It pops one 12-bit word at a time from a non-empty VC FIFO, holds it, decodes its destination field, and pushes it into one of four destination FIFOs once that FIFO is not almost full. It obeys the same one-hot `state` control bus as the FIFOs, so a single controller sequences the whole layer.

---
 rtl/vc_arbiter_if.sv | 34 +++
 rtl/vc_arbiter.sv | 136 +++++++++++++
 tb/tb_vc_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if
//   Handshake bundle between the vc_arbiter and the FIFOs around it.
//   master : arbiter side (drives pops, destination push and data).
//   slave  : FIFO side (drives VC data/empty and destination almost_full).
// Signals:
//   vc0_data/vc1_data   VC FIFO data_out
//   vc0_empty/vc1_empty VC FIFO empty flags
//   vc0_pop/vc1_pop     pop strobes to the VC FIFOs
//   d_almost_full[3:0]  almost_full of destination FIFOs 0..3
//   d_push[3:0]         one-hot push strobe to destination FIFOs
//   d_data              word driven to all destination FIFOs
interface vc_arbiter_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] vc0_data;
    logic              vc0_empty;
    logic              vc0_pop;
    logic [DATA_W-1:0] vc1_data;
    logic              vc1_empty;
    logic              vc1_pop;
    logic [3:0]        d_almost_full;
    logic [3:0]        d_push;
    logic [DATA_W-1:0] d_data;

    modport master (
        input  vc0_data, vc0_empty, vc1_data, vc1_empty, d_almost_full,
        output vc0_pop, vc1_pop, d_push, d_data
    );

    modport slave (
        output vc0_data, vc0_empty, vc1_data, vc1_empty, d_almost_full,
        input  vc0_pop, vc1_pop, d_push, d_data
    );
endinterface

// File: rtl/vc_arbiter.sv
// vc_arbiter
//   Dequeue/routing stage behind the two virtual-channel FIFOs. Pops one
//   word from a non-empty VC, holds it, decodes the 2-bit destination field
//   and pushes it into the selected destination FIFO once that FIFO is not
//   almost full. Sequenced by the same one-hot layer control bus as the FIFOs.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   state  in   one-hot control: 0001 soft reset, 0010 init, 0100 idle,
//               1000 active (only active allows new grants)
//   bus    master modport of vc_arbiter_if (VC pops, destination pushes)
//   busy   out  high whenever the FSM is outside ARB
// Configuration:
//   VC_ARB_STRICT_PRIO_EN  defined: VC0 always wins when non-empty.
//                          undefined: round-robin between VC0 and VC1.
// Timing: grant at edge k, pop high k..k+1, capture at k+2, push at k+3
// when the destination is free; the next grant can happen at k+4.
module vc_arbiter #(
    parameter int DATA_W   = 12,
    parameter int DEST_LSB = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   state,
    vc_arbiter_if.master bus,
    output logic         busy
);

    typedef enum logic [1:0] {
        ARB,
        WAIT,
        CAP,
        SEND
    } fsm_t;

    fsm_t              fsm;
    logic [DATA_W-1:0] hold;
    logic              sel;        // 0: VC0, 1: VC1
`ifndef VC_ARB_STRICT_PRIO_EN
    logic              ptr;        // VC that gets first chance at the next grant
`endif

    logic       soft_rst;
    logic       active;
    logic       eligible;
    logic       grant_vc1;
    logic [1:0] dest;
    logic       dest_free;

    assign soft_rst = (state == 4'b0001);
    assign active   = (state == 4'b1000);
    assign eligible = active && !(bus.vc0_empty && bus.vc1_empty);

    // Only meaningful when eligible: picks VC1 when it has priority and
    // words, or when VC0 has nothing to offer.
    always_comb begin
        grant_vc1 = 1'b0;
`ifdef VC_ARB_STRICT_PRIO_EN
        grant_vc1 = bus.vc0_empty;
`else
        if (ptr) grant_vc1 = !bus.vc1_empty;
        else     grant_vc1 = bus.vc0_empty;
`endif
    end

    assign dest      = hold[DEST_LSB +: 2];
    assign dest_free = !bus.d_almost_full[dest];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm         <= ARB;
            hold        <= '0;
            sel         <= 1'b0;
`ifndef VC_ARB_STRICT_PRIO_EN
            ptr         <= 1'b0;
`endif
            bus.vc0_pop <= 1'b0;
            bus.vc1_pop <= 1'b0;
            bus.d_push  <= '0;
            bus.d_data  <= '0;
            busy        <= 1'b0;
        end else if (soft_rst) begin
            fsm         <= ARB;
            hold        <= '0;
            sel         <= 1'b0;
`ifndef VC_ARB_STRICT_PRIO_EN
            ptr         <= 1'b0;
`endif
            bus.vc0_pop <= 1'b0;
            bus.vc1_pop <= 1'b0;
            bus.d_push  <= '0;
            bus.d_data  <= '0;
            busy        <= 1'b0;
        end else begin
            // Strobes are single-cycle by default; d_data keeps its value.
            bus.vc0_pop <= 1'b0;
            bus.vc1_pop <= 1'b0;
            bus.d_push  <= '0;
            case (fsm)
                ARB: begin
                    if (eligible) begin
                        bus.vc0_pop <= !grant_vc1;
                        bus.vc1_pop <= grant_vc1;
                        sel         <= grant_vc1;
                        fsm         <= WAIT;
                        busy        <= 1'b1;
                    end
                end
                WAIT: begin
                    // FIFO presents the popped word on data_out at this edge.
                    fsm <= CAP;
                end
                CAP: begin
                    hold <= sel ? bus.vc1_data : bus.vc0_data;
                    fsm  <= SEND;
                end
                SEND: begin
                    if (dest_free) begin
                        bus.d_data <= hold;
                        bus.d_push <= 4'b0001 << dest;
`ifndef VC_ARB_STRICT_PRIO_EN
                        ptr        <= ~sel;
`endif
                        fsm        <= ARB;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    fsm  <= ARB;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter
//   Directed bench for vc_arbiter: two VC FIFO models with registered
//   data_out feed the DUT; expected pushes are queued as words are loaded
//   and compared by a monitor whenever the DUT asserts d_push.
module tb_vc_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] state;
    logic       busy;

    vc_arbiter_if #(.DATA_W(12)) bus ();

    vc_arbiter #(.DATA_W(12), .DEST_LSB(10)) dut (
        .clk   (clk),
        .reset (reset),
        .state (state),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // VC FIFO models: data_out updates on the edge that samples pop.
    logic [11:0] vc0_mem [0:63];
    logic [11:0] vc1_mem [0:63];
    int vc0_wr = 0, vc0_rd = 0, vc1_wr = 0, vc1_rd = 0;

    always @(posedge clk) begin
        if (bus.vc0_pop) begin
            bus.vc0_data <= vc0_mem[vc0_rd[5:0]];
            vc0_rd       <= vc0_rd + 1;
        end
        if (bus.vc1_pop) begin
            bus.vc1_data <= vc1_mem[vc1_rd[5:0]];
            vc1_rd       <= vc1_rd + 1;
        end
    end
    assign bus.vc0_empty = (vc0_wr == vc0_rd);
    assign bus.vc1_empty = (vc1_wr == vc1_rd);

    typedef struct {
        logic [11:0] data;
        logic [3:0]  push;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [11:0] w);
        logic [3:0] r;
        r = 4'b0000;
        r[w[11:10]] = 1'b1;
        return r;
    endfunction

    task automatic load0(input logic [11:0] w, input bit expect_it);
        exp_t e;
        vc0_mem[vc0_wr[5:0]] = w;
        vc0_wr = vc0_wr + 1;
        if (expect_it) begin
            e.data = w; e.push = onehot(w); sb.push_back(e);
        end
    endtask

    task automatic load1(input logic [11:0] w, input bit expect_it);
        exp_t e;
        vc1_mem[vc1_wr[5:0]] = w;
        vc1_wr = vc1_wr + 1;
        if (expect_it) begin
            e.data = w; e.push = onehot(w); sb.push_back(e);
        end
    endtask

    task automatic expect_word(input logic [11:0] w);
        exp_t e;
        e.data = w; e.push = onehot(w); sb.push_back(e);
    endtask

    task automatic wait_push(input string tag, input int max, output int at);
        bit hit;
        hit = 1'b0;
        at  = -1;
        for (int i = 0; i < max && !hit; i++) begin
            @(negedge clk);
            if (bus.d_push != 4'b0000) begin
                hit = 1'b1;
                at  = cyc;
            end
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic wait_pop(input string tag, input int max);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            @(negedge clk);
            if (bus.vc0_pop || bus.vc1_pop) hit = 1'b1;
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    // Scoreboard monitor plus one-at-a-time strobe check.
    always @(negedge clk) begin
        if (bus.vc0_pop && bus.vc1_pop) chk("dual_pop", 32'd1, 32'd0);
        if (bus.d_push != 4'b0000) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_push: observed push=%b data=%h expected none",
                       bus.d_push, bus.d_data);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_push", {28'd0, bus.d_push}, {28'd0, e.push});
                chk("sb_data", {20'd0, bus.d_data}, {20'd0, e.data});
            end
        end
    end

    int t_at;
    int t_prev;

    initial begin
        reset = 1'b0;
        state = 4'b1000;
        bus.d_almost_full = 4'b0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pop0", {31'd0, bus.vc0_pop}, 32'd0);
        chk("rst_pop1", {31'd0, bus.vc1_pop}, 32'd0);
        chk("rst_push", {28'd0, bus.d_push}, 32'd0);
        chk("rst_data", {20'd0, bus.d_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_nopop", {30'd0, bus.vc0_pop, bus.vc1_pop}, 32'd0);
        end

        // Single word, exact timing
        load0(12'hA5C, 1'b1);
        @(negedge clk); chk("sw_pop_c1", {31'd0, bus.vc0_pop}, 32'd1);
                        chk("sw_busy_c1", {31'd0, busy}, 32'd1);
        @(negedge clk); chk("sw_pop_c2", {31'd0, bus.vc0_pop}, 32'd0);
        @(negedge clk); chk("sw_push_c3", {28'd0, bus.d_push}, 32'd0);
        @(negedge clk); chk("sw_push_c4", {28'd0, bus.d_push}, 32'h4);
                        chk("sw_data_c4", {20'd0, bus.d_data}, 32'hA5C);
        @(negedge clk); chk("sw_push_c5", {28'd0, bus.d_push}, 32'd0);
                        chk("sw_data_hold", {20'd0, bus.d_data}, 32'hA5C);

        // Async reset mid-SEND discards the held word
        bus.d_almost_full = 4'b0010;
        load1(12'h401, 1'b0);
        wait_pop("mr_pop", 10);
        repeat (4) @(negedge clk);
        chk("mr_blocked", {28'd0, bus.d_push}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_busy_clr", {31'd0, busy}, 32'd0);
        chk("mr_data_clr", {20'd0, bus.d_data}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.d_almost_full = 4'b0000;
        repeat (6) begin
            @(negedge clk);
            chk("mr_no_push", {28'd0, bus.d_push}, 32'd0);
        end

        // Round-robin (or strict priority) burst, pushes every 4 cycles
`ifdef VC_ARB_STRICT_PRIO_EN
        load0(12'h011, 1'b1); load0(12'h412, 1'b1); load0(12'h813, 1'b1); load0(12'hC14, 1'b1);
        load1(12'h421, 1'b1); load1(12'h822, 1'b1); load1(12'hC23, 1'b1); load1(12'h024, 1'b1);
`else
        load0(12'h011, 1'b1); load1(12'h421, 1'b1);
        load0(12'h412, 1'b1); load1(12'h822, 1'b1);
        load0(12'h813, 1'b1); load1(12'hC23, 1'b1);
        load0(12'hC14, 1'b1); load1(12'h024, 1'b1);
`endif
        t_prev = -1;
        for (int i = 0; i < 8; i++) begin
            wait_push("rr_push", 12, t_at);
            if (i > 0) chk("rr_spacing", t_at - t_prev, 32'd4);
            t_prev = t_at;
        end

        // Backpressure on dest 3
        bus.d_almost_full = 4'b1000;
        load0(12'hC01, 1'b1);
        repeat (8) begin
            @(negedge clk);
            chk("bp_no_push", {28'd0, bus.d_push}, 32'd0);
        end
        chk("bp_busy", {31'd0, busy}, 32'd1);
        bus.d_almost_full = 4'b0000;
        @(negedge clk);
        chk("bp_push", {28'd0, bus.d_push}, 32'h8);
        chk("bp_data", {20'd0, bus.d_data}, 32'hC01);

        // Control gating: idle blocks grants
        state = 4'b0100;
        load0(12'h035, 1'b0);
        load1(12'h436, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("gate_nopop", {30'd0, bus.vc0_pop, bus.vc1_pop}, 32'd0);
        end
`ifdef VC_ARB_STRICT_PRIO_EN
        expect_word(12'h035);
`else
        expect_word(12'h436);
`endif
        state = 4'b1000;
        wait_pop("gate_pop", 4);
        state = 4'b0100;      // now in WAIT: word must still complete
        wait_push("gate_inflight", 8, t_at);
        repeat (6) begin
            @(negedge clk);
            chk("gate_hold", {30'd0, bus.vc0_pop, bus.vc1_pop}, 32'd0);
        end
`ifdef VC_ARB_STRICT_PRIO_EN
        expect_word(12'h436);
`else
        expect_word(12'h035);
`endif
        state = 4'b1000;
        wait_push("gate_resume", 8, t_at);

        // Soft reset while in CAP
        load0(12'h8AA, 1'b0);
        wait_pop("sr_pop", 6);
        @(negedge clk);       // FSM in CAP
        state = 4'b0001;
        @(negedge clk);
        chk("sr_busy", {31'd0, busy}, 32'd0);
        chk("sr_push", {28'd0, bus.d_push}, 32'd0);
        chk("sr_data", {20'd0, bus.d_data}, 32'd0);
        chk("sr_pops", {30'd0, bus.vc0_pop, bus.vc1_pop}, 32'd0);
        state = 4'b1000;
        repeat (8) begin
            @(negedge clk);
            chk("sr_no_push", {28'd0, bus.d_push}, 32'd0);
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
